// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding, reset/size defaults,
// fetch FSM state encoding and the IF/ID update selector.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int          IMEM_WORDS_DEFAULT = 2048;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-state mux: load (word aligned) > hold > +4.
// Priority between load and hold is resolved by the caller.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        load_en,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    logic [31:0] pc_value_reg;
    logic [31:0] pc_value_next;

    always_comb begin
        pc_value_next = pc_value_reg;
        if (load_en) begin
            pc_value_next = {load_pc[31:2], 2'b00};
        end else if (!hold) begin
            // Plain 32-bit add: 0xFFFF_FFFC wraps to 0.
            pc_value_next = pc_value_reg + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_value_reg <= RESET_PC;
        end else begin
            pc_value_reg <= pc_value_next;
        end
    end

    assign pc = pc_value_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC (via pc_reg), BOOT/RUN FSM and the IF/ID pipeline register.
// Optional out-of-range fetch trap enabled by defining IF_RANGE_CHECK_EN.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
`ifdef IF_RANGE_CHECK_EN
    ,
    output logic        fetch_err
`endif
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    ifid_op_t     ifid_op;
    logic         pc_hold;
    logic         pc_load;
    logic         freeze;
    logic [31:0]  pc;

    logic         if_id_valid_reg;
    logic [31:0]  if_id_instr_reg;
    logic [31:0]  if_id_pc_reg;
    logic [31:0]  if_id_pc4_reg;

`ifdef IF_RANGE_CHECK_EN
    logic fetch_err_reg;
    logic range_hit;

    assign range_hit = (state_reg == ST_RUN) && ({2'b00, pc[31:2]} >= 32'(IMEM_WORDS));
    // Once tripped the stage stays frozen until reset, redirects included.
    assign freeze    = fetch_err_reg | range_hit;
    assign fetch_err = fetch_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err_reg <= 1'b0;
        end else if (range_hit) begin
            fetch_err_reg <= 1'b1;
        end
    end
`else
    logic unused_imem_words;

    assign freeze            = 1'b0;
    assign unused_imem_words = ^32'(IMEM_WORDS);
`endif

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .hold    (pc_hold),
        .load_en (pc_load),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Edge priority: freeze > redirect > boot > flush > stall > normal fetch.
    always_comb begin
        state_next = ST_RUN;
        ifid_op    = IFID_LOAD;
        pc_hold    = 1'b0;
        pc_load    = 1'b0;
        if (freeze) begin
            ifid_op = IFID_HOLD;
            pc_hold = 1'b1;
        end else if (redirect_valid) begin
            ifid_op = IFID_BUBBLE;
            pc_load = 1'b1;
        end else if (state_reg == ST_BOOT) begin
            ifid_op = IFID_BUBBLE;
            pc_hold = 1'b1;
        end else if (flush) begin
            ifid_op = IFID_BUBBLE;
            pc_hold = stall;
        end else if (stall) begin
            ifid_op = IFID_HOLD;
            pc_hold = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ifid_op == IFID_BUBBLE) begin
            if_id_valid_reg <= 1'b0;
            if_id_instr_reg <= NOP_INSTR;
            if_id_pc_reg    <= 32'h0;
            if_id_pc4_reg   <= 32'h0;
        end else if (ifid_op == IFID_LOAD) begin
            if_id_valid_reg <= 1'b1;
            if_id_instr_reg <= imem_rdata;
            if_id_pc_reg    <= pc;
            if_id_pc4_reg   <= pc + 32'd4;
        end
    end

    assign imem_addr   = pc;
    assign imem_rd_en  = ~rst;
    assign if_id_valid = if_id_valid_reg;
    assign if_id_instr = if_id_instr_reg;
    assign if_id_pc    = if_id_pc_reg;
    assign if_id_pc4   = if_id_pc4_reg;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table driven through a scoreboard queue,
// plus hand sequences for reset-over-redirect, PC wrap and (if enabled) the range trap.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc, if_id_pc4;
    logic        imem_rd_en, if_id_valid;

    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;
    logic        w_rd_en, w_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[31:2])
            30'd0:   return 32'h0000_0011;
            30'd1:   return 32'h0000_0022;
            30'd2:   return 32'h0000_0033;
            30'd3:   return 32'h0000_0044;
            default: return {8'hC0, a[23:0]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

`ifdef IF_RANGE_CHECK_EN
    logic        fetch_err, w_fetch_err, r_fetch_err;
    logic [31:0] r_addr, r_rdata, r_instr, r_pc, r_pc4;
    logic        r_rd_en, r_valid;
    assign r_rdata = mem_word(r_addr);
`endif

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
`ifdef IF_RANGE_CHECK_EN
        , .fetch_err(fetch_err)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(w_addr), .imem_rd_en(w_rd_en), .imem_rdata(w_rdata),
        .if_id_valid(w_valid), .if_id_instr(w_instr),
        .if_id_pc(w_pc), .if_id_pc4(w_pc4)
`ifdef IF_RANGE_CHECK_EN
        , .fetch_err(w_fetch_err)
`endif
    );

`ifdef IF_RANGE_CHECK_EN
    if_stage #(.IMEM_WORDS(4)) dut_range (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(r_addr), .imem_rd_en(r_rd_en), .imem_rdata(r_rdata),
        .if_id_valid(r_valid), .if_id_instr(r_instr),
        .if_id_pc(r_pc), .if_id_pc4(r_pc4), .fetch_err(r_fetch_err)
    );
`endif

    typedef struct {
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [31:0] ea;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] addr;
    } exp_t;

    vec_t  vecs[19];
    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    logic [31:0] wrap_exp[3];

    function automatic vec_t mkv(input logic s, input logic f, input logic rv,
                                 input logic [31:0] rpc, input logic ev,
                                 input logic [31:0] ei, input logic [31:0] ep,
                                 input logic [31:0] ea);
        vec_t v;
        v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        vec_t v;

        vecs[0]  = mkv(0, 0, 0, 32'h0,   0, 32'h0,         32'h0,   32'h0);
        vecs[1]  = mkv(0, 0, 0, 32'h0,   1, 32'h11,        32'h0,   32'h4);
        vecs[2]  = mkv(0, 0, 0, 32'h0,   1, 32'h22,        32'h4,   32'h8);
        vecs[3]  = mkv(0, 0, 0, 32'h0,   1, 32'h33,        32'h8,   32'hC);
        vecs[4]  = mkv(0, 0, 0, 32'h0,   1, 32'h44,        32'hC,   32'h10);
        vecs[5]  = mkv(1, 0, 0, 32'h0,   1, 32'h44,        32'hC,   32'h10);
        vecs[6]  = mkv(1, 0, 0, 32'h0,   1, 32'h44,        32'hC,   32'h10);
        vecs[7]  = mkv(1, 0, 0, 32'h0,   1, 32'h44,        32'hC,   32'h10);
        vecs[8]  = mkv(0, 0, 0, 32'h0,   1, 32'hC000_0010, 32'h10,  32'h14);
        vecs[9]  = mkv(1, 0, 1, 32'h43,  0, 32'h0,         32'h0,   32'h40);
        vecs[10] = mkv(0, 0, 0, 32'h0,   1, 32'hC000_0040, 32'h40,  32'h44);
        vecs[11] = mkv(0, 0, 1, 32'h20,  0, 32'h0,         32'h0,   32'h20);
        vecs[12] = mkv(0, 1, 0, 32'h0,   0, 32'h0,         32'h0,   32'h24);
        vecs[13] = mkv(0, 0, 0, 32'h0,   1, 32'hC000_0024, 32'h24,  32'h28);
        vecs[14] = mkv(1, 1, 0, 32'h0,   0, 32'h0,         32'h0,   32'h28);
        vecs[15] = mkv(0, 0, 0, 32'h0,   1, 32'hC000_0028, 32'h28,  32'h2C);
        vecs[16] = mkv(1, 0, 0, 32'h0,   1, 32'hC000_0028, 32'h28,  32'h2C);
        vecs[17] = mkv(0, 1, 1, 32'h102, 0, 32'h0,         32'h0,   32'h100);
        vecs[18] = mkv(0, 0, 0, 32'h0,   1, 32'hC000_0100, 32'h100, 32'h104);
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick();
        tick();
        chk("reset_rd_en",   {31'h0, imem_rd_en},  32'h0);
        chk("reset_valid",   {31'h0, if_id_valid}, 32'h0);
        chk("reset_instr",   if_id_instr,          32'h0);
        chk("reset_pc",      if_id_pc,             32'h0);
        chk("reset_pc4",     if_id_pc4,            32'h0);
        chk("reset_addr",    imem_addr,            32'h0);
        chk("reset_wrap_pc", w_addr,               32'hFFFF_FFF8);

        rst = 1'b0;
        #1;
        chk("run_rd_en", {31'h0, imem_rd_en}, 32'h1);

        for (int i = 0; i < 19; i++) begin
            v = vecs[i];
            stall = v.stall; flush = v.flush; redirect_valid = v.rv; redirect_pc = v.rpc;
            e.valid = v.ev; e.instr = v.ei; e.pc = v.ep;
            e.pc4 = v.ev ? v.ep + 32'd4 : 32'h0;
            e.addr = v.ea;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            chk($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, e.valid});
            chk($sformatf("v%0d_instr", i), if_id_instr, e.instr);
            chk($sformatf("v%0d_pc",    i), if_id_pc,    e.pc);
            chk($sformatf("v%0d_pc4",   i), if_id_pc4,   e.pc4);
            chk($sformatf("v%0d_addr",  i), imem_addr,   e.addr);
            if (i < 3) chk($sformatf("wrap_pc%0d", i), w_addr, wrap_exp[i]);
            $display("vec %0d: stall=%0b flush=%0b redir=%0b valid=%0b instr=%08h pc=%08h addr=%08h",
                     i, v.stall, v.flush, v.rv, if_id_valid, if_id_instr, if_id_pc, imem_addr);
        end

        // Reset taken while a stall and a redirect are pending: nothing carries over.
        rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        chk("rstover_addr",  imem_addr,            32'h0);
        chk("rstover_valid", {31'h0, if_id_valid}, 32'h0);
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick();
        chk("rstover_boot_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rstover_boot_addr",  imem_addr,            32'h0);
        tick();
        chk("rstover_first_instr", if_id_instr, 32'h11);
        chk("rstover_first_addr",  imem_addr,   32'h4);
        $display("reset-over-redirect: valid=%0b instr=%08h addr=%08h", if_id_valid, if_id_instr, imem_addr);

`ifdef IF_RANGE_CHECK_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("range_pre_err",  {31'h0, r_fetch_err}, 32'h0);
        chk("range_pre_addr", r_addr,               32'h10);
        tick();
        chk("range_err",       {31'h0, r_fetch_err}, 32'h1);
        chk("range_stuck",     r_addr,               32'h10);
        chk("range_hold_inst", r_instr,              32'h44);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("range_redir_ignored", r_addr,               32'h10);
        chk("range_sticky",        {31'h0, r_fetch_err}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("range_rst_clear", {31'h0, r_fetch_err}, 32'h0);
        chk("range_rst_addr",  r_addr,               32'h0);
        $display("range trap: err=%0b addr=%08h", r_fetch_err, r_addr);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
